// File: rtl/fifo_controller.sv
// fifo_controller: byte FIFO controller over an external multi-bank byte memory
// Ports:
//   clk, reset (async, active-low), flush (sync clear of pointers/count/FSM)
//   push_valid/push_ready/push_width/push_data/push_err : multi-byte push side,
//     first byte in the most significant occupied lane of push_data
//   mem_write_enable/mem_write_width/mem_write_addr/mem_data_in : memory write side
//   mem_read_addr/mem_data_out : memory read side, sampled at the end of FETCH
//   pop_valid/pop_ready/pop_data : single-byte stream to the consumer
//   count/empty/full : occupancy, including the byte held on pop_data
module fifo_controller #(
  parameter int AddrWidth  = 8,
  parameter int EntryWidth = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [2:0]              push_width,
  input  logic [8*EntryWidth-1:0] push_data,
  output logic                    push_err,
  output logic                    mem_write_enable,
  output logic [2:0]              mem_write_width,
  output logic [AddrWidth-1:0]    mem_write_addr,
  output logic [8*EntryWidth-1:0] mem_data_in,
  output logic [AddrWidth-1:0]    mem_read_addr,
  input  logic [7:0]              mem_data_out,
  output logic                    pop_valid,
  input  logic                    pop_ready,
  output logic [7:0]              pop_data,
  output logic [AddrWidth:0]      count,
  output logic                    empty,
  output logic                    full
);
  localparam logic [AddrWidth:0] DepthW = {1'b1, {AddrWidth{1'b0}}};
  localparam logic [2:0]         MaxW   = 3'(EntryWidth);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;
  state_e               state_q, state_d;
  logic [AddrWidth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AddrWidth:0]   count_q, count_d, w_ext;
  logic [7:0]           data_q, data_d;
  logic                 width_ok, push_go, pop_go;
  assign w_ext    = (AddrWidth+1)'(push_width);
  assign width_ok = push_width != 3'd0 && push_width <= MaxW;
  // Illegal widths are "accepted" so the producer never stalls on them; they only raise push_err.
  assign push_ready = !width_ok || (!flush && DepthW - count_q >= w_ext);
  assign push_go    = reset && push_valid && push_ready && width_ok;
  assign push_err   = reset && push_valid && !width_ok;
  assign pop_go     = state_q == HOLD && pop_ready && !flush;
  assign mem_write_enable = push_go;
  assign mem_write_width  = push_width;
  assign mem_write_addr   = wptr_q;
  assign mem_data_in      = push_data;
  assign mem_read_addr    = rptr_q;
  assign pop_valid = state_q == HOLD;
  assign pop_data  = data_q;
  assign count     = count_q;
  assign empty     = count_q == '0;
  assign full      = count_q == DepthW;
  // Only the registered count starts a fetch; the held byte is still in count while in HOLD,
  // so leaving HOLD looks for a second byte (count > 1).
  always_comb begin
    state_d = flush ? IDLE
            : state_q == IDLE  ? (count_q != '0 ? FETCH : IDLE)
            : state_q == FETCH ? HOLD
            : pop_ready ? (|count_q[AddrWidth:1] ? FETCH : IDLE) : HOLD;
    data_d  = state_q == FETCH ? mem_data_out : data_q;
    wptr_d  = flush ? '0 : push_go ? wptr_q + AddrWidth'(push_width) : wptr_q;
    rptr_d  = flush ? '0 : rptr_q + AddrWidth'(pop_go);
    count_d = flush ? '0 : count_q + (push_go ? w_ext : '0) - (AddrWidth+1)'(pop_go);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_fifo_controller.sv
// tb_fifo_controller: randomized + directed self-checking bench for fifo_controller
module tb_fifo_controller;
  localparam int AW = 4;
  localparam int EW = 4;
  localparam int DEPTH = 1 << AW;
  logic clk = 0, reset = 0, flush = 0, push_valid = 0, pop_ready = 0;
  logic [2:0] push_width = 0;
  logic [8*EW-1:0] push_data = 0;
  logic push_ready, push_err, mem_write_enable, pop_valid, empty, full;
  logic [2:0] mem_write_width;
  logic [AW-1:0] mem_write_addr, mem_read_addr;
  logic [8*EW-1:0] mem_data_in;
  logic [7:0] mem_data_out, pop_data;
  logic [AW:0] count;
  logic [7:0] mem [DEPTH];
  logic [7:0] q[$];
  logic [7:0] got[$];
  int n_chk = 0, n_err = 0, wr_total = 0, rd_total = 0, stall = 0, pr_pct = 50;
  bit last_acc;

  fifo_controller #(.AddrWidth(AW), .EntryWidth(EW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_width(push_width),
    .push_data(push_data), .push_err(push_err),
    .mem_write_enable(mem_write_enable), .mem_write_width(mem_write_width),
    .mem_write_addr(mem_write_addr), .mem_data_in(mem_data_in),
    .mem_read_addr(mem_read_addr), .mem_data_out(mem_data_out),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_write_enable)
      for (int i = 0; i < int'(mem_write_width); i++)
        mem[(int'(mem_write_addr) + i) % DEPTH] <= mem_data_in[8*(int'(mem_write_width)-1-i) +: 8];
  assign mem_data_out = mem[mem_read_addr];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    int w;
    bit legal, rdy, we, hs;
    @(negedge clk);
    w = int'(push_width);
    legal = w >= 1 && w <= EW;
    rdy = !legal || (!flush && DEPTH - q.size() >= w);
    we = push_valid && legal && rdy;
    last_acc = we;
    chk("push_ready", push_ready, rdy);
    chk("push_err", push_err, push_valid && !legal);
    chk("mem_we", mem_write_enable, we);
    if (we) begin
      chk("wr_addr", mem_write_addr, wr_total % DEPTH);
      chk("wr_width", mem_write_width, w);
      chk("wr_data", mem_data_in, push_data);
    end
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("popv_q", pop_valid && q.size() == 0, 0);
    if (q.size() != 0 && !pop_valid) stall++; else stall = 0;
    if (q.size() != 0) chk("stall", stall <= 2, 1);
    if (pop_valid) chk("rd_addr", mem_read_addr, rd_total % DEPTH);
    hs = pop_valid && pop_ready && !flush;
    if (hs && q.size() != 0) chk("pop_data", pop_data, q[0]);
    @(posedge clk);
    if (flush) begin
      q.delete();
      wr_total = 0;
      rd_total = 0;
      stall = 0;
    end else begin
      if (hs && q.size() != 0) begin
        got.push_back(q.pop_front());
        rd_total++;
      end
      if (we) begin
        for (int i = 0; i < w; i++) q.push_back(push_data[8*(w-1-i) +: 8]);
        wr_total += w;
      end
    end
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_wait(int w, logic [31:0] d);
    bit ok = 0;
    push_valid = 1;
    push_width = 3'(w);
    push_data = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      ok = last_acc;
    end
    chk("push_timeout", ok, 1);
    push_valid = 0;
  endtask

  task automatic wait_popv();
    for (int i = 0; i < 10 && !pop_valid; i++) step();
    chk("popv_timeout", pop_valid, 1);
  endtask

  task automatic do_flush();
    flush = 1;
    push_valid = 0;
    step();
    flush = 0;
  endtask

  initial begin
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_popv", pop_valid, 0);
    chk("rst_popd", pop_data, 0);
    chk("rst_we", mem_write_enable, 0);
    @(posedge clk);
    #1 reset = 1;

    // single 4-byte entry pops out in lane order
    push_wait(4, 32'h11223344);
    pop_ready = 1;
    got.delete();
    run(12);
    chk("ord_n", got.size(), 4);
    if (got.size() == 4) begin
      chk("ord0", got[0], 8'h11);
      chk("ord1", got[1], 8'h22);
      chk("ord2", got[2], 8'h33);
      chk("ord3", got[3], 8'h44);
    end
    chk("ord_empty", empty, 1);

    // fill to Depth-2, oversize push refused, exact fit accepted
    do_flush();
    pop_ready = 0;
    push_wait(4, $urandom);
    push_wait(4, $urandom);
    push_wait(4, $urandom);
    push_wait(2, $urandom);
    chk("cnt14", count, DEPTH - 2);
    push_valid = 1;
    push_width = 3;
    #1 chk("ready3", push_ready, 0);
    step();
    push_valid = 0;
    chk("cnt14b", count, DEPTH - 2);
    push_wait(2, $urandom);
    chk("full", full, 1);
    chk("cnt16", count, DEPTH);

    // wrap of a 4-byte entry across the end of the buffer
    do_flush();
    pop_ready = 1;
    push_wait(4, $urandom);
    push_wait(4, $urandom);
    push_wait(4, $urandom);
    push_wait(3, $urandom);
    run(40);
    chk("drain_empty", empty, 1);
    push_valid = 1;
    push_width = 4;
    push_data = 32'hA1B2C3D4;
    #1 chk("wrap_addr", mem_write_addr, DEPTH - 1);
    step();
    push_valid = 0;
    got.delete();
    run(12);
    chk("wrap_n", got.size(), 4);
    if (got.size() == 4) begin
      chk("wrap0", got[0], 8'hA1);
      chk("wrap3", got[3], 8'hD4);
    end
    pop_ready = 0;
    push_valid = 1;
    push_width = 1;
    #1 chk("wrap_next", mem_write_addr, 3);
    step();
    push_valid = 0;

    // simultaneous push and pop in HOLD
    do_flush();
    push_wait(4, $urandom);
    push_wait(1, $urandom);
    wait_popv();
    chk("cnt5", count, 5);
    push_valid = 1;
    push_width = 2;
    pop_ready = 1;
    step();
    push_valid = 0;
    pop_ready = 0;
    chk("cnt6", count, 6);

    // zero-width push
    push_valid = 1;
    push_width = 0;
    #1 chk("err_pulse", push_err, 1);
    chk("err_we", mem_write_enable, 0);
    step();
    push_valid = 0;
    #1 chk("err_low", push_err, 0);
    chk("err_cnt", count, 6);

    // async reset while holding a byte
    do_flush();
    push_wait(3, $urandom);
    wait_popv();
    chk("hold_cnt3", count, 3);
    push_valid = 1;
    push_width = 4;
    #2 reset = 0;
    #1;
    chk("ar_popv", pop_valid, 0);
    chk("ar_popd", pop_data, 0);
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_full", full, 0);
    chk("ar_err", push_err, 0);
    chk("ar_we", mem_write_enable, 0);
    push_valid = 0;
    @(posedge clk);
    #1 reset = 1;
    q.delete();
    wr_total = 0;
    rd_total = 0;
    stall = 0;
    pop_ready = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ar_after", pop_valid, 0);
    end

    // randomized traffic against the byte-queue model
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) pr_pct = $urandom_range(15, 95);
      push_valid = $urandom_range(0, 3) != 0;
      push_width = 3'($urandom_range(0, 6));
      push_data = $urandom;
      pop_ready = $urandom_range(0, 99) < pr_pct;
      flush = $urandom_range(0, 99) == 0;
      step();
    end
    flush = 0;
    push_valid = 0;
    pop_ready = 1;
    run(2 * DEPTH + 8);
    chk("final_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
